// File: rtl/msg_checker.sv
// rtl/msg_checker.sv - checks received UART bytes against a fixed 16-byte line; optional capture macro MSG_CHECKER_CAPTURE_EN
module msg_checker #(
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       rdy,
    output logic       line_ok,
    output logic       line_err,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt,
    output logic [3:0] char_pos,
    output logic [7:0] err_data,
    output logic [3:0] err_pos
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_MATCH  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [7:0]  CH_H      = 8'h48;
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [23:0] IDLE_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_pos;
    logic [3:0]  w_pos_nxt;
    logic [23:0] r_idle;
    logic [23:0] w_idle_nxt;
    logic        r_line_ok;
    logic        r_line_err;
    logic [7:0]  r_ok_cnt;
    logic [7:0]  r_err_cnt;
    logic        w_ok_evt;
    logic        w_err_evt;
    logic [7:0]  w_expected;

    always_comb begin
        w_expected = 8'h00;
        case (r_pos)
            4'd0:  w_expected = 8'h48;
            4'd1:  w_expected = 8'h65;
            4'd2:  w_expected = 8'h6C;
            4'd3:  w_expected = 8'h6C;
            4'd4:  w_expected = 8'h6F;
            4'd5:  w_expected = 8'h20;
            4'd6:  w_expected = 8'h77;
            4'd7:  w_expected = 8'h6F;
            4'd8:  w_expected = 8'h72;
            4'd9:  w_expected = 8'h6C;
            4'd10: w_expected = 8'h64;
            4'd11: w_expected = 8'h21;
            4'd12: w_expected = 8'h20;
            4'd13: w_expected = 8'h20;
            4'd14: w_expected = 8'h0D;
            4'd15: w_expected = 8'h0A;
            default: w_expected = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_idle_nxt  = 24'd0;
        w_ok_evt    = 1'b0;
        w_err_evt   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (rdy && data == CH_H) begin
                    w_state_nxt = ST_MATCH;
                    w_pos_nxt   = 4'd1;
                end
            end
            ST_MATCH: begin
                // A byte arriving on the timeout cycle wins; the timeout is dropped.
                if (rdy) begin
                    if (data == w_expected) begin
                        if (r_pos == 4'd15) begin
                            w_ok_evt    = 1'b1;
                            w_pos_nxt   = 4'd0;
                            w_state_nxt = ST_HUNT;
                        end else begin
                            w_pos_nxt = r_pos + 4'd1;
                        end
                    end else begin
                        w_err_evt   = 1'b1;
                        w_pos_nxt   = 4'd0;
                        w_state_nxt = (data == CH_LF) ? ST_HUNT : ST_RESYNC;
                    end
                end else if (r_idle == IDLE_LAST) begin
                    w_err_evt   = 1'b1;
                    w_pos_nxt   = 4'd0;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_idle_nxt = r_idle + 24'd1;
                end
            end
            ST_RESYNC: begin
                if (rdy && data == CH_LF) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
                w_pos_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HUNT;
            r_pos      <= 4'd0;
            r_idle     <= 24'd0;
            r_line_ok  <= 1'b0;
            r_line_err <= 1'b0;
            r_ok_cnt   <= 8'd0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_idle     <= w_idle_nxt;
            r_line_ok  <= w_ok_evt;
            r_line_err <= w_err_evt;
            if (w_ok_evt && r_ok_cnt != 8'hFF) begin
                r_ok_cnt <= r_ok_cnt + 8'd1;
            end
            if (w_err_evt && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

`ifdef MSG_CHECKER_CAPTURE_EN
    logic [7:0] r_err_data;
    logic [3:0] r_err_pos;

    // An error with rdy high can only be a mismatch; timeouts never have rdy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_data <= 8'd0;
            r_err_pos  <= 4'd0;
        end else if (w_err_evt && rdy) begin
            r_err_data <= data;
            r_err_pos  <= r_pos;
        end
    end

    assign err_data = r_err_data;
    assign err_pos  = r_err_pos;
`else
    assign err_data = 8'd0;
    assign err_pos  = 4'd0;
`endif

    assign line_ok  = r_line_ok;
    assign line_err = r_line_err;
    assign ok_cnt   = r_ok_cnt;
    assign err_cnt  = r_err_cnt;
    assign char_pos = r_pos;

endmodule
